// File: rtl/rs_dispatch.sv
// Reservation station: holds renamed add/sub/mul/div ops, captures operands from the CDB
// and dispatches one ready op per cycle. Define RS_AGE_SELECT_EN for oldest-first select.
module rs_dispatch #(
   parameter int ENTRIES = 3,
   parameter int MD_LAT  = 3
) (
   input  logic       clk1,
   input  logic       rst,
   input  logic       iss_valid,
   output logic       iss_ready,
   input  logic [3:0] iss_func,
   input  logic [3:0] iss_rd,
   input  logic [2:0] iss_rob,
   input  logic [7:0] iss_v1,
   input  logic [7:0] iss_v2,
   input  logic [2:0] iss_q1,
   input  logic [2:0] iss_q2,
   input  logic       iss_r1,
   input  logic       iss_r2,
   input  logic       cdb_valid,
   input  logic [2:0] cdb_rob,
   input  logic [7:0] cdb_data,
   input  logic       flush,
   output logic       exec_b,
   output logic [2:0] rs_index,
   output logic [7:0] rs1_data,
   output logic [7:0] rs2_data,
   output logic [3:0] func,
   output logic [2:0] rob_ind,
   output logic [3:0] rd,
   output logic       illegal
);
   logic [ENTRIES-1:0] busy, r1, r2;
   logic [3:0]         s_func [ENTRIES];
   logic [3:0]         s_rd   [ENTRIES];
   logic [2:0]         s_rob  [ENTRIES];
   logic [7:0]         s_v1   [ENTRIES];
   logic [7:0]         s_v2   [ENTRIES];
   logic [2:0]         s_q1   [ENTRIES];
   logic [2:0]         s_q2   [ENTRIES];
   logic [3:0]         md_cnt;
`ifdef RS_AGE_SELECT_EN
   logic [ENTRIES-1:0] older  [ENTRIES];  // older[j][i]: slot j was inserted before slot i
`endif

   logic [ENTRIES-1:0] elig, cand, sel_oh, ins_oh, busy_nxt;
   logic               sel_hit, ins_hit, cap1, cap2;
   logic [2:0]         sel_idx, sel_rob;
   logic [3:0]         sel_func, sel_rd;
   logic [7:0]         sel_v1, sel_v2;

   always_comb begin
      iss_ready = ~&busy;
      cap1      = cdb_valid && !iss_r1 && (cdb_rob == iss_q1);
      cap2      = cdb_valid && !iss_r2 && (cdb_rob == iss_q2);

      // func[3:1]==000 is add/sub, 001 is mul/div; anything else never dispatches
      for (int i = 0; i < ENTRIES; i++) begin
         elig[i] = busy[i] && r1[i] && r2[i] &&
                   ((s_func[i][3:1] == 3'b000) ||
                    ((s_func[i][3:1] == 3'b001) && (md_cnt == 4'd0)));
      end

`ifdef RS_AGE_SELECT_EN
      for (int i = 0; i < ENTRIES; i++) begin
         cand[i] = elig[i];
         for (int j = 0; j < ENTRIES; j++) begin
            if (elig[j] && older[j][i]) cand[i] = 1'b0;
         end
      end
`else
      cand = elig;
`endif

      sel_hit  = 1'b0;
      sel_oh   = '0;
      sel_idx  = '0;
      sel_func = '0;
      sel_rd   = '0;
      sel_rob  = '0;
      sel_v1   = '0;
      sel_v2   = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (cand[i]) begin
            sel_hit  = 1'b1;
            sel_oh   = ENTRIES'(1) << i;
            sel_idx  = 3'(i);
            sel_func = s_func[i];
            sel_rd   = s_rd[i];
            sel_rob  = s_rob[i];
            sel_v1   = s_v1[i];
            sel_v2   = s_v2[i];
         end
      end

      ins_oh = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (!busy[i]) ins_oh = ENTRIES'(1) << i;
      end
      ins_hit = iss_valid && iss_ready;

      // unsupported opcodes hold their slot for exactly one cycle
      busy_nxt = busy & ~sel_oh;
      for (int i = 0; i < ENTRIES; i++) begin
         if (s_func[i][3:2] != 2'b00) busy_nxt[i] = 1'b0;
      end
      if (ins_hit) busy_nxt = busy_nxt | ins_oh;
   end

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         busy     <= '0;
         r1       <= '0;
         r2       <= '0;
         md_cnt   <= '0;
         exec_b   <= 1'b0;
         rs_index <= '0;
         rs1_data <= '0;
         rs2_data <= '0;
         func     <= '0;
         rob_ind  <= '0;
         rd       <= '0;
         illegal  <= 1'b0;
         for (int i = 0; i < ENTRIES; i++) begin
            s_func[i] <= '0;
            s_rd[i]   <= '0;
            s_rob[i]  <= '0;
            s_v1[i]   <= '0;
            s_v2[i]   <= '0;
            s_q1[i]   <= '0;
            s_q2[i]   <= '0;
`ifdef RS_AGE_SELECT_EN
            older[i]  <= '0;
`endif
         end
      end else if (flush) begin
         busy   <= '0;
         md_cnt <= '0;
         exec_b <= 1'b0;
      end else begin
         busy   <= busy_nxt;
         exec_b <= sel_hit;
         if (sel_hit) begin
            rs_index <= sel_idx;
            rs1_data <= sel_v1;
            rs2_data <= sel_v2;
            func     <= sel_func;
            rob_ind  <= sel_rob;
            rd       <= sel_rd;
         end
         if (sel_hit && sel_func[1]) md_cnt <= 4'(MD_LAT - 1);
         else if (md_cnt != 4'd0)    md_cnt <= md_cnt - 4'd1;
         if (ins_hit && (iss_func[3:2] != 2'b00)) illegal <= 1'b1;

         for (int i = 0; i < ENTRIES; i++) begin
            if (cdb_valid && busy[i] && !r1[i] && (s_q1[i] == cdb_rob)) begin
               s_v1[i] <= cdb_data;
               r1[i]   <= 1'b1;
            end
            if (cdb_valid && busy[i] && !r2[i] && (s_q2[i] == cdb_rob)) begin
               s_v2[i] <= cdb_data;
               r2[i]   <= 1'b1;
            end
            if (ins_hit && ins_oh[i]) begin
               s_func[i] <= iss_func;
               s_rd[i]   <= iss_rd;
               s_rob[i]  <= iss_rob;
               s_q1[i]   <= iss_q1;
               s_q2[i]   <= iss_q2;
               s_v1[i]   <= cap1 ? cdb_data : iss_v1;
               s_v2[i]   <= cap2 ? cdb_data : iss_v2;
               r1[i]     <= iss_r1 | cap1;
               r2[i]     <= iss_r2 | cap2;
            end
         end

`ifdef RS_AGE_SELECT_EN
         if (ins_hit) begin
            for (int j = 0; j < ENTRIES; j++) begin
               older[j] <= ins_oh[j] ? '0 : (older[j] | ins_oh);
            end
         end
`endif
      end
   end
endmodule

// File: tb/tb_rs_dispatch.sv
// Bench for rs_dispatch: queue-based insertion-order model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_rs_dispatch;
   localparam int ENTRIES = 3;
   localparam int MD_LAT  = 3;

   logic       clk1 = 1'b0;
   logic       rst;
   logic       iss_valid;
   logic       iss_ready;
   logic [3:0] iss_func, iss_rd;
   logic [2:0] iss_rob, iss_q1, iss_q2;
   logic [7:0] iss_v1, iss_v2;
   logic       iss_r1, iss_r2;
   logic       cdb_valid;
   logic [2:0] cdb_rob;
   logic [7:0] cdb_data;
   logic       flush;
   logic       exec_b;
   logic [2:0] rs_index, rob_ind;
   logic [7:0] rs1_data, rs2_data;
   logic [3:0] func, rd;
   logic       illegal;

   rs_dispatch #(.ENTRIES(ENTRIES), .MD_LAT(MD_LAT)) dut (
      .clk1(clk1), .rst(rst),
      .iss_valid(iss_valid), .iss_ready(iss_ready),
      .iss_func(iss_func), .iss_rd(iss_rd), .iss_rob(iss_rob),
      .iss_v1(iss_v1), .iss_v2(iss_v2), .iss_q1(iss_q1), .iss_q2(iss_q2),
      .iss_r1(iss_r1), .iss_r2(iss_r2),
      .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_data(cdb_data),
      .flush(flush),
      .exec_b(exec_b), .rs_index(rs_index), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .func(func), .rob_ind(rob_ind), .rd(rd), .illegal(illegal)
   );

   always #5 clk1 = ~clk1;

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: live entries kept in insertion order; the slot number is just a label.
   typedef struct {
      logic [3:0] f;
      logic [3:0] d;
      logic [2:0] rb;
      logic [7:0] v1, v2;
      logic [2:0] q1, q2;
      logic       r1, r2;
      int         slot;
   } ent_t;

   ent_t       mq[$];
   int         cyc     = 0;
   int         last_md = -1000;
   logic       m_exec  = 1'b0;
   logic [2:0] m_idx   = '0;
   logic [7:0] m_rs1   = '0;
   logic [7:0] m_rs2   = '0;
   logic [3:0] m_func  = '0;
   logic [2:0] m_rob   = '0;
   logic [3:0] m_rd    = '0;
   logic       m_ill   = 1'b0;

   function automatic bit m_elig(input ent_t e);
      bit addsub = (e.f == 4'd0) || (e.f == 4'd1);
      bit muldiv = (e.f == 4'd2) || (e.f == 4'd3);
      return e.r1 && e.r2 && (addsub || (muldiv && (cyc - last_md) >= MD_LAT));
   endfunction

   task automatic model_reset();
      mq.delete();
      last_md = -1000;
      m_exec = 1'b0; m_idx = '0; m_rs1 = '0; m_rs2 = '0;
      m_func = '0; m_rob = '0; m_rd = '0; m_ill = 1'b0;
   endtask

   task automatic model_step();
      ent_t nq[$];
      ent_t e;
      int   sel, fs;
      bit   used [ENTRIES];
      cyc++;
      if (flush) begin
         mq.delete();
         last_md = -1000;
         m_exec  = 1'b0;
         return;
      end
      sel = -1;
      foreach (mq[k]) begin
         if (m_elig(mq[k])) begin
`ifdef RS_AGE_SELECT_EN
            if (sel < 0) sel = k;
`else
            if (sel < 0 || mq[k].slot < mq[sel].slot) sel = k;
`endif
         end
      end
      for (int s = 0; s < ENTRIES; s++) used[s] = 1'b0;
      foreach (mq[k]) used[mq[k].slot] = 1'b1;
      fs = -1;
      for (int s = ENTRIES - 1; s >= 0; s--) if (!used[s]) fs = s;

      m_exec = (sel >= 0);
      if (sel >= 0) begin
         m_idx  = 3'(mq[sel].slot);
         m_rs1  = mq[sel].v1;
         m_rs2  = mq[sel].v2;
         m_func = mq[sel].f;
         m_rob  = mq[sel].rb;
         m_rd   = mq[sel].d;
         if (mq[sel].f == 4'd2 || mq[sel].f == 4'd3) last_md = cyc;
      end

      foreach (mq[k]) begin
         if (k != sel && mq[k].f <= 4'd3) begin
            e = mq[k];
            if (cdb_valid && !e.r1 && e.q1 == cdb_rob) begin e.v1 = cdb_data; e.r1 = 1'b1; end
            if (cdb_valid && !e.r2 && e.q2 == cdb_rob) begin e.v2 = cdb_data; e.r2 = 1'b1; end
            nq.push_back(e);
         end
      end

      if (iss_valid && fs >= 0) begin
         e.f = iss_func; e.d = iss_rd; e.rb = iss_rob;
         e.q1 = iss_q1; e.q2 = iss_q2;
         e.v1 = iss_v1; e.r1 = iss_r1;
         e.v2 = iss_v2; e.r2 = iss_r2;
         if (cdb_valid && !iss_r1 && iss_q1 == cdb_rob) begin e.v1 = cdb_data; e.r1 = 1'b1; end
         if (cdb_valid && !iss_r2 && iss_q2 == cdb_rob) begin e.v2 = cdb_data; e.r2 = 1'b1; end
         e.slot = fs;
         if (iss_func > 4'd3) m_ill = 1'b1;
         nq.push_back(e);
      end
      mq = nq;
   endtask

   always @(posedge clk1 or posedge rst) begin
      if (rst) model_reset();
      else     model_step();
   end

   always @(negedge clk1) begin
      chk("cmp_exec_b",    32'(exec_b),    32'(m_exec));
      chk("cmp_iss_ready", 32'(iss_ready), 32'(mq.size() < ENTRIES));
      chk("cmp_illegal",   32'(illegal),   32'(m_ill));
      chk("cmp_rs_index",  32'(rs_index),  32'(m_idx));
      chk("cmp_rs1_data",  32'(rs1_data),  32'(m_rs1));
      chk("cmp_rs2_data",  32'(rs2_data),  32'(m_rs2));
      chk("cmp_func",      32'(func),      32'(m_func));
      chk("cmp_rob_ind",   32'(rob_ind),   32'(m_rob));
      chk("cmp_rd",        32'(rd),        32'(m_rd));
   end

   task automatic tick();
      @(posedge clk1);
      #1;
   endtask

   task automatic issue(input logic [3:0] f, input logic [3:0] d, input logic [2:0] rb,
                        input logic [7:0] a, input logic ra, input logic [2:0] qa,
                        input logic [7:0] b, input logic rbr, input logic [2:0] qb);
      iss_valid = 1'b1;
      iss_func = f; iss_rd = d; iss_rob = rb;
      iss_v1 = a; iss_r1 = ra; iss_q1 = qa;
      iss_v2 = b; iss_r2 = rbr; iss_q2 = qb;
      tick();
      iss_valid = 1'b0;
   endtask

   task automatic cdb(input logic v, input logic [2:0] tag, input logic [7:0] data);
      cdb_valid = v; cdb_rob = tag; cdb_data = data;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; iss_valid = 1'b0;
      iss_func = '0; iss_rd = '0; iss_rob = '0; iss_v1 = '0; iss_v2 = '0;
      iss_q1 = '0; iss_q2 = '0; iss_r1 = 1'b0; iss_r2 = 1'b0;
      cdb(1'b0, 3'd0, 8'h00);
      repeat (2) @(posedge clk1);
      #1 rst = 1'b0;
      chk("reset_exec_b", 32'(exec_b), 32'd0);
      chk("reset_iss_ready", 32'(iss_ready), 32'd1);
      chk("reset_illegal", 32'(illegal), 32'd0);
      chk("reset_rs1", 32'(rs1_data), 32'd0);

      // ready add
      issue(4'd0, 4'h5, 3'd2, 8'h05, 1'b1, 3'd0, 8'h03, 1'b1, 3'd0);
      chk("add_not_yet", 32'(exec_b), 32'd0);
      tick();
      chk("add_exec", 32'(exec_b), 32'd1);
      chk("add_func", 32'(func), 32'h0);
      chk("add_rs1", 32'(rs1_data), 32'h05);
      chk("add_rs2", 32'(rs2_data), 32'h03);
      chk("add_rob", 32'(rob_ind), 32'd2);
      chk("add_rd", 32'(rd), 32'h5);
      chk("add_idx", 32'(rs_index), 32'd0);
      tick();
      chk("add_one_shot", 32'(exec_b), 32'd0);

      // CDB wakeup
      issue(4'd1, 4'h6, 3'd3, 8'h00, 1'b0, 3'd1, 8'h10, 1'b1, 3'd0);
      chk("wake_wait0", 32'(exec_b), 32'd0);
      tick();
      chk("wake_wait1", 32'(exec_b), 32'd0);
      cdb(1'b1, 3'd1, 8'h0A);
      tick();
      cdb(1'b0, 3'd0, 8'h00);
      chk("wake_plus1", 32'(exec_b), 32'd0);
      tick();
      chk("wake_plus2", 32'(exec_b), 32'd1);
      chk("wake_rs1", 32'(rs1_data), 32'h0A);
      chk("wake_rs2", 32'(rs2_data), 32'h10);
      chk("wake_func", 32'(func), 32'h1);
      tick();

      // insert-time capture
      cdb(1'b1, 3'd4, 8'h77);
      issue(4'd0, 4'h7, 3'd4, 8'h01, 1'b1, 3'd0, 8'h00, 1'b0, 3'd4);
      cdb(1'b0, 3'd0, 8'h00);
      tick();
      chk("cap_exec", 32'(exec_b), 32'd1);
      chk("cap_rs2", 32'(rs2_data), 32'h77);
      chk("cap_rs1", 32'(rs1_data), 32'h01);
      tick();

      // full
      issue(4'd1, 4'h1, 3'd1, 8'h00, 1'b0, 3'd5, 8'h02, 1'b1, 3'd0);
      issue(4'd1, 4'h2, 3'd2, 8'h00, 1'b0, 3'd6, 8'h02, 1'b1, 3'd0);
      issue(4'd1, 4'h3, 3'd5, 8'h00, 1'b0, 3'd7, 8'h02, 1'b1, 3'd0);
      chk("full_ready", 32'(iss_ready), 32'd0);
      issue(4'd0, 4'hF, 3'd6, 8'h11, 1'b1, 3'd0, 8'h22, 1'b1, 3'd0);
      chk("full_ignored0", 32'(exec_b), 32'd0);
      tick();
      chk("full_ignored1", 32'(exec_b), 32'd0);
      chk("full_still", 32'(iss_ready), 32'd0);
      cdb(1'b1, 3'd6, 8'h66);
      tick();
      cdb(1'b0, 3'd0, 8'h00);
      chk("full_woken_ready", 32'(iss_ready), 32'd0);
      tick();
      chk("full_exec", 32'(exec_b), 32'd1);
      chk("full_idx", 32'(rs_index), 32'd1);
      chk("full_rs1", 32'(rs1_data), 32'h66);
      chk("full_ready_back", 32'(iss_ready), 32'd1);

      // flush with slots 0 and 2 busy
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_ready", 32'(iss_ready), 32'd1);
      cdb(1'b1, 3'd5, 8'h55);
      tick();
      cdb(1'b1, 3'd7, 8'h57);
      tick();
      cdb(1'b0, 3'd0, 8'h00);
      chk("flush_none0", 32'(exec_b), 32'd0);
      tick();
      chk("flush_none1", 32'(exec_b), 32'd0);
      tick();
      chk("flush_none2", 32'(exec_b), 32'd0);

      // mul/div spacing with add interleave
      issue(4'd2, 4'h1, 3'd1, 8'h03, 1'b1, 3'd0, 8'h04, 1'b1, 3'd0);
      chk("md_wait", 32'(exec_b), 32'd0);
      issue(4'd2, 4'h2, 3'd2, 8'h05, 1'b1, 3'd0, 8'h06, 1'b1, 3'd0);
      chk("md_first", 32'(exec_b), 32'd1);
      chk("md_first_rd", 32'(rd), 32'h1);
      issue(4'd0, 4'h3, 3'd3, 8'h07, 1'b1, 3'd0, 8'h08, 1'b1, 3'd0);
      chk("md_gap", 32'(exec_b), 32'd0);
      tick();
      chk("md_add", 32'(exec_b), 32'd1);
      chk("md_add_rd", 32'(rd), 32'h3);
      chk("md_add_idx", 32'(rs_index), 32'd0);
      tick();
      chk("md_second", 32'(exec_b), 32'd1);
      chk("md_second_rd", 32'(rd), 32'h2);
      chk("md_second_idx", 32'(rs_index), 32'd1);
      tick();
      chk("md_done", 32'(exec_b), 32'd0);

      // unsupported opcode
      issue(4'h9, 4'h0, 3'd0, 8'h00, 1'b1, 3'd0, 8'h00, 1'b1, 3'd0);
      chk("ill_set", 32'(illegal), 32'd1);
      chk("ill_no_exec", 32'(exec_b), 32'd0);
      tick();
      chk("ill_sticky", 32'(illegal), 32'd1);
      chk("ill_no_exec2", 32'(exec_b), 32'd0);

      // reset during a wakeup
      issue(4'd1, 4'hA, 3'd6, 8'h00, 1'b0, 3'd2, 8'h09, 1'b1, 3'd0);
      cdb(1'b1, 3'd2, 8'h22);
      #2 rst = 1'b1;
      #1;
      chk("rst_exec", 32'(exec_b), 32'd0);
      chk("rst_idx", 32'(rs_index), 32'd0);
      chk("rst_rs1", 32'(rs1_data), 32'd0);
      chk("rst_rs2", 32'(rs2_data), 32'd0);
      chk("rst_func", 32'(func), 32'd0);
      chk("rst_rob", 32'(rob_ind), 32'd0);
      chk("rst_rd", 32'(rd), 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      chk("rst_ready", 32'(iss_ready), 32'd1);
      @(posedge clk1);
      #1 rst = 1'b0;
      cdb(1'b0, 3'd0, 8'h00);
      tick();
      chk("rst_lost0", 32'(exec_b), 32'd0);
      tick();
      chk("rst_lost1", 32'(exec_b), 32'd0);

      // select order: slot 2 is older than the re-filled slot 0
      issue(4'd0, 4'hA, 3'd1, 8'h01, 1'b0, 3'd5, 8'h02, 1'b1, 3'd0);
      issue(4'd0, 4'hB, 3'd2, 8'h03, 1'b0, 3'd6, 8'h04, 1'b1, 3'd0);
      issue(4'd1, 4'hC, 3'd3, 8'h05, 1'b0, 3'd7, 8'h06, 1'b1, 3'd0);
      cdb(1'b1, 3'd5, 8'h50);
      tick();
      cdb(1'b0, 3'd0, 8'h00);
      tick();
      chk("ord_a_exec", 32'(exec_b), 32'd1);
      chk("ord_a_rd", 32'(rd), 32'hA);
      chk("ord_a_rs1", 32'(rs1_data), 32'h50);
      issue(4'd0, 4'hD, 3'd4, 8'h00, 1'b0, 3'd7, 8'h08, 1'b1, 3'd0);
      cdb(1'b1, 3'd7, 8'h70);
      tick();
      cdb(1'b0, 3'd0, 8'h00);
      tick();
      chk("ord_first_exec", 32'(exec_b), 32'd1);
`ifdef RS_AGE_SELECT_EN
      chk("ord_first_idx", 32'(rs_index), 32'd2);
      chk("ord_first_rd", 32'(rd), 32'hC);
`else
      chk("ord_first_idx", 32'(rs_index), 32'd0);
      chk("ord_first_rd", 32'(rd), 32'hD);
`endif
      tick();
      chk("ord_second_exec", 32'(exec_b), 32'd1);
`ifdef RS_AGE_SELECT_EN
      chk("ord_second_idx", 32'(rs_index), 32'd0);
      chk("ord_second_rd", 32'(rd), 32'hD);
`else
      chk("ord_second_idx", 32'(rs_index), 32'd2);
      chk("ord_second_rd", 32'(rd), 32'hC);
`endif
      chk("ord_second_rs1", 32'(rs1_data), 32'h70);

      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      chk("end_idle", 32'(exec_b), 32'd0);
      chk("end_ready", 32'(iss_ready), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
